xintf_wr_arbiter: RTL and testbench

Shares the Zynq-side write port of the Zynq→DSP XINTF DPBRAM between three requesters:
- port 0: interlock/clear updates
- port 1: periodic setpoint/gain block
- port 2: SFP-slave setpoint mirror

It grants one requester at a time with round-robin priority. It streams that requester's burst into the DPBRAM at consecutive addresses, then runs the valid/ready commit handshake with the DSP. It sits between the register-staging logic and the DPBRAM primitive, and replaces direct per-source drive of the CE/address/data lines.

---
 rtl/xintf_wr_arbiter_if.sv | 42 ++++
 rtl/xintf_wr_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_xintf_wr_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xintf_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : xintf_wr_arbiter_if
// Brief    : Request/grant/DPBRAM/handshake bundle for the XINTF write arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface xintf_wr_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 7
);
    logic [2:0]          i_req;
    logic [3*ADDR_W-1:0] i_req_addr;
    logic [3*LEN_W-1:0]  i_req_len;
    logic [3*DATA_W-1:0] i_wr_data;
    logic [2:0]          o_gnt;
    logic [2:0]          o_data_ack;
    logic [2:0]          o_done;
    logic                o_timeout;
    logic [ADDR_W-1:0]   o_xintf_z_to_d_addr;
    logic [DATA_W-1:0]   o_xintf_z_to_d_din;
    logic                o_xintf_z_to_d_ce;
    logic                o_w_valid;
    logic                i_w_ready;

    // Arbiter side
    modport slave (
        input  i_req, i_req_addr, i_req_len, i_wr_data, i_w_ready,
        output o_gnt, o_data_ack, o_done, o_timeout,
               o_xintf_z_to_d_addr, o_xintf_z_to_d_din, o_xintf_z_to_d_ce,
               o_w_valid
    );

    // Requesters plus DSP side
    modport master (
        output i_req, i_req_addr, i_req_len, i_wr_data, i_w_ready,
        input  o_gnt, o_data_ack, o_done, o_timeout,
               o_xintf_z_to_d_addr, o_xintf_z_to_d_din, o_xintf_z_to_d_ce,
               o_w_valid
    );
endinterface
`default_nettype wire

// File: rtl/xintf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : xintf_wr_arbiter
// Brief    : Round-robin 3-port burst writer into the Zynq->DSP XINTF DPBRAM
//            with valid/ready commit handshake toward the DSP.
// Revision : 1.0 - initial release
// ============================================================================
module xintf_wr_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 7,
    parameter int TIMEOUT = 1024
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst,
    xintf_wr_arbiter_if.slave bus
);

    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BURST     = 3'd1,
        ST_FLUSH     = 3'd2,
        ST_HANDSHAKE = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t            state_q;
    logic [2:0]        gnt_q;
    logic [1:0]        gidx_q;
    logic [1:0]        last_gnt_q;
    logic [ADDR_W-1:0] addr_cnt_q;
    logic [LEN_W-1:0]  word_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [2:0]        done_q;
    logic              timeout_q;
    logic              ce_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;

    logic              w_win_vld;
    logic [1:0]        w_win_idx;
    logic [2:0]        w_win_oh;
    logic [ADDR_W-1:0] w_win_addr;
    logic [LEN_W-1:0]  w_win_len;
    logic [DATA_W-1:0] w_gnt_data;
    logic [ADDR_W-1:0] addr_cnt_d;
    logic [LEN_W-1:0]  word_cnt_d;
    logic [TO_W-1:0]   to_cnt_d;
    logic              w_to_expired;

    // Search order starts one past the last served port and ends on it.
    always_comb begin
        w_win_vld = |bus.i_req;
        w_win_idx = 2'd0;
        case (last_gnt_q)
            2'd0: begin
                if      (bus.i_req[1]) w_win_idx = 2'd1;
                else if (bus.i_req[2]) w_win_idx = 2'd2;
                else                   w_win_idx = 2'd0;
            end
            2'd1: begin
                if      (bus.i_req[2]) w_win_idx = 2'd2;
                else if (bus.i_req[0]) w_win_idx = 2'd0;
                else                   w_win_idx = 2'd1;
            end
            default: begin
                if      (bus.i_req[0]) w_win_idx = 2'd0;
                else if (bus.i_req[1]) w_win_idx = 2'd1;
                else                   w_win_idx = 2'd2;
            end
        endcase
        w_win_oh = 3'b001 << w_win_idx;
    end

    always_comb begin
        w_win_addr = bus.i_req_addr[0 +: ADDR_W];
        w_win_len  = bus.i_req_len[0 +: LEN_W];
        case (w_win_idx)
            2'd1: begin
                w_win_addr = bus.i_req_addr[ADDR_W +: ADDR_W];
                w_win_len  = bus.i_req_len[LEN_W +: LEN_W];
            end
            2'd2: begin
                w_win_addr = bus.i_req_addr[2*ADDR_W +: ADDR_W];
                w_win_len  = bus.i_req_len[2*LEN_W +: LEN_W];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_gnt_data = bus.i_wr_data[0 +: DATA_W];
        case (gidx_q)
            2'd1:    w_gnt_data = bus.i_wr_data[DATA_W +: DATA_W];
            2'd2:    w_gnt_data = bus.i_wr_data[2*DATA_W +: DATA_W];
            default: ;
        endcase
    end

    // Address counter wraps naturally at 2^ADDR_W.
    assign addr_cnt_d   = addr_cnt_q + 1'b1;
    assign word_cnt_d   = word_cnt_q - 1'b1;
    assign to_cnt_d     = to_cnt_q + 1'b1;
    assign w_to_expired = (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gidx_q     <= '0;
            last_gnt_q <= 2'd2;
            addr_cnt_q <= '0;
            word_cnt_q <= '0;
            to_cnt_q   <= '0;
            done_q     <= '0;
            timeout_q  <= 1'b0;
            ce_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            // Write strobe and pulses are single-cycle unless BURST re-arms them.
            done_q    <= '0;
            timeout_q <= 1'b0;
            ce_q      <= 1'b0;
            addr_q    <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (w_win_vld) begin
                        gnt_q      <= w_win_oh;
                        gidx_q     <= w_win_idx;
                        addr_cnt_q <= w_win_addr;
                        word_cnt_q <= w_win_len;
                        if (w_win_len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= w_win_oh;
                        end else begin
                            state_q <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    ce_q       <= 1'b1;
                    addr_q     <= addr_cnt_q;
                    din_q      <= w_gnt_data;
                    addr_cnt_q <= addr_cnt_d;
                    word_cnt_q <= word_cnt_d;
                    if (word_cnt_q == LEN_W'(1)) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    to_cnt_q <= '0;
                    state_q  <= ST_HANDSHAKE;
                end
                ST_HANDSHAKE: begin
                    // Ready wins over a coincident expiry.
                    if (bus.i_w_ready) begin
                        state_q <= ST_DONE;
                        done_q  <= gnt_q;
                    end else if (w_to_expired) begin
                        state_q   <= ST_DONE;
                        done_q    <= gnt_q;
                        timeout_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                    end
                end
                ST_DONE: begin
                    last_gnt_q <= gidx_q;
                    gnt_q      <= '0;
                    to_cnt_q   <= '0;
                    word_cnt_q <= '0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.o_gnt               = gnt_q;
    assign bus.o_data_ack          = (state_q == ST_BURST) ? gnt_q : 3'b000;
    assign bus.o_done              = done_q;
    assign bus.o_timeout           = timeout_q;
    assign bus.o_xintf_z_to_d_addr = addr_q;
    assign bus.o_xintf_z_to_d_din  = din_q;
    assign bus.o_xintf_z_to_d_ce   = ce_q;
    assign bus.o_w_valid           = (state_q == ST_HANDSHAKE);

endmodule
`default_nettype wire

// File: tb/tb_xintf_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_xintf_wr_arbiter
// Brief    : Directed self-checking bench for xintf_wr_arbiter
// Revision : 1.0 - initial release
// ============================================================================
module tb_xintf_wr_arbiter;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int LW = 7;
    localparam int TO = 16;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [15:0] base [3];
    logic [15:0] cnt  [3];
    logic [2:0]  ack_n;

    xintf_wr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    xintf_wr_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .LEN_W  (LW),
        .TIMEOUT(TO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Requester data model: next word presented the cycle after an ack.
    assign bus.i_wr_data = {base[2] + cnt[2], base[1] + cnt[1], base[0] + cnt[0]};

    always @(negedge clk) ack_n = bus.o_data_ack;

    always @(posedge clk) begin
        #1;
        for (int n = 0; n < 3; n++) begin
            if (ack_n[n]) cnt[n] = cnt[n] + 16'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_port(input int n, input int addr, input int len, input logic [15:0] b);
        bus.i_req_addr[n*AW +: AW] = AW'(addr);
        bus.i_req_len[n*LW +: LW]  = LW'(len);
        base[n] = b;
        cnt[n]  = 16'd0;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.i_req     = 3'b000;
        bus.i_w_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (bus.o_gnt !== 3'b000 || bus.o_data_ack !== 3'b000 || bus.o_done !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_gnt_ack_done: got %b/%b/%b want 000/000/000",
                     bus.o_gnt, bus.o_data_ack, bus.o_done);
        end
        n_tests++;
        if (bus.o_xintf_z_to_d_ce !== 1'b0 || bus.o_xintf_z_to_d_addr !== 9'd0 ||
            bus.o_xintf_z_to_d_din !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_bram: got ce=%b addr=%0d din=%h want 0/0/0000",
                     bus.o_xintf_z_to_d_ce, bus.o_xintf_z_to_d_addr, bus.o_xintf_z_to_d_din);
        end
        n_tests++;
        if (bus.o_w_valid !== 1'b0 || bus.o_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_timeout: got %b/%b want 0/0", bus.o_w_valid, bus.o_timeout);
        end
    endtask

    task automatic test_single_burst();
        apply_reset();
        set_port(1, 40, 4, 16'hA000);
        bus.i_req = 3'b010;
        tick(); // t1
        n_tests++;
        if (bus.o_gnt !== 3'b010 || bus.o_data_ack !== 3'b010 || bus.o_xintf_z_to_d_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL single_t1: got gnt=%b ack=%b ce=%b want 010/010/0",
                     bus.o_gnt, bus.o_data_ack, bus.o_xintf_z_to_d_ce);
        end
        for (int k = 0; k < 4; k++) begin
            tick(); // t2..t5
            n_tests++;
            if (bus.o_xintf_z_to_d_ce !== 1'b1 || bus.o_xintf_z_to_d_addr !== 9'(40 + k) ||
                bus.o_xintf_z_to_d_din !== 16'(16'hA000 + k)) begin
                n_fail++;
                $display("FAIL single_write%0d: got ce=%b addr=%0d din=%h want 1/%0d/%h", k,
                         bus.o_xintf_z_to_d_ce, bus.o_xintf_z_to_d_addr, bus.o_xintf_z_to_d_din,
                         40 + k, 16'hA000 + k);
            end
        end
        tick(); // t6
        n_tests++;
        if (bus.o_w_valid !== 1'b1 || bus.o_xintf_z_to_d_ce !== 1'b0 || bus.o_xintf_z_to_d_addr !== 9'd0) begin
            n_fail++;
            $display("FAIL single_t6: got valid=%b ce=%b addr=%0d want 1/0/0",
                     bus.o_w_valid, bus.o_xintf_z_to_d_ce, bus.o_xintf_z_to_d_addr);
        end
        tick(); // t7
        tick(); // t8
        n_tests++;
        if (bus.o_w_valid !== 1'b1 || bus.o_done !== 3'b000) begin
            n_fail++;
            $display("FAIL single_t8: got valid=%b done=%b want 1/000", bus.o_w_valid, bus.o_done);
        end
        bus.i_w_ready = 1'b1;
        tick(); // t9
        n_tests++;
        if (bus.o_done !== 3'b010 || bus.o_w_valid !== 1'b0 || bus.o_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got done=%b valid=%b to=%b want 010/0/0",
                     bus.o_done, bus.o_w_valid, bus.o_timeout);
        end
        bus.i_req     = 3'b000;
        bus.i_w_ready = 1'b0;
        tick(); // t10
        n_tests++;
        if (bus.o_gnt !== 3'b000 || bus.o_done !== 3'b000) begin
            n_fail++;
            $display("FAIL single_idle: got gnt=%b done=%b want 000/000", bus.o_gnt, bus.o_done);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [6];
        logic [2:0] prev;
        int         ngr;
        int         bad;
        apply_reset();
        set_port(0, 16, 2, 16'h1000);
        set_port(1, 32, 2, 16'h2000);
        set_port(2, 48, 2, 16'h3000);
        bus.i_w_ready = 1'b1;
        bus.i_req     = 3'b111;
        prev = 3'b000;
        ngr  = 0;
        bad  = 0;
        for (int c = 0; c < 80 && ngr < 6; c++) begin
            tick();
            if ($countones(bus.o_gnt) > 1) bad++;
            if (bus.o_gnt !== 3'b000 && prev === 3'b000) begin
                order[ngr] = bus.o_gnt[0] ? 2'd0 : (bus.o_gnt[1] ? 2'd1 : 2'd2);
                ngr++;
            end
            prev = bus.o_gnt;
        end
        n_tests++;
        if (ngr != 6) begin
            n_fail++;
            $display("FAIL rr_count: got %0d grants want 6", ngr);
        end
        for (int k = 0; k < ngr; k++) begin
            n_tests++;
            if (order[k] !== 2'(k % 3)) begin
                n_fail++;
                $display("FAIL rr_order%0d: got port %0d want port %0d", k, order[k], k % 3);
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rr_onehot: got %0d multi-grant cycles want 0", bad);
        end
        bus.i_req     = 3'b000;
        bus.i_w_ready = 1'b0;
    endtask

    task automatic test_addr_wrap();
        int exp_addr [3];
        exp_addr = '{510, 511, 0};
        apply_reset();
        set_port(0, 510, 3, 16'h7700);
        bus.i_w_ready = 1'b1;
        bus.i_req     = 3'b001;
        tick(); // t1
        for (int k = 0; k < 3; k++) begin
            tick(); // t2..t4
            n_tests++;
            if (bus.o_xintf_z_to_d_ce !== 1'b1 || bus.o_xintf_z_to_d_addr !== 9'(exp_addr[k])) begin
                n_fail++;
                $display("FAIL wrap_write%0d: got ce=%b addr=%0d want 1/%0d", k,
                         bus.o_xintf_z_to_d_ce, bus.o_xintf_z_to_d_addr, exp_addr[k]);
            end
        end
        tick(); // t5: handshake with ready already high
        n_tests++;
        if (bus.o_w_valid !== 1'b1 || bus.o_xintf_z_to_d_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_valid: got valid=%b ce=%b want 1/0", bus.o_w_valid, bus.o_xintf_z_to_d_ce);
        end
        tick(); // t6
        n_tests++;
        if (bus.o_w_valid !== 1'b0 || bus.o_done !== 3'b001) begin
            n_fail++;
            $display("FAIL wrap_done: got valid=%b done=%b want 0/001", bus.o_w_valid, bus.o_done);
        end
        bus.i_req     = 3'b000;
        bus.i_w_ready = 1'b0;
    endtask

    task automatic test_zero_length();
        apply_reset();
        set_port(2, 77, 0, 16'h9900);
        bus.i_req = 3'b100;
        tick(); // t1
        n_tests++;
        if (bus.o_gnt !== 3'b100 || bus.o_done !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_done: got gnt=%b done=%b want 100/100", bus.o_gnt, bus.o_done);
        end
        n_tests++;
        if (bus.o_data_ack !== 3'b000 || bus.o_xintf_z_to_d_ce !== 1'b0 || bus.o_w_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_quiet: got ack=%b ce=%b valid=%b want 000/0/0",
                     bus.o_data_ack, bus.o_xintf_z_to_d_ce, bus.o_w_valid);
        end
        bus.i_req = 3'b000;
        tick(); // t2
        n_tests++;
        if (bus.o_gnt !== 3'b000 || bus.o_done !== 3'b000 || bus.o_xintf_z_to_d_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_exit: got gnt=%b done=%b ce=%b want 000/000/0",
                     bus.o_gnt, bus.o_done, bus.o_xintf_z_to_d_ce);
        end
    endtask

    task automatic test_timeout();
        int vcyc;
        int tocnt;
        bit got_done;
        bit got_gnt;
        apply_reset();
        set_port(0, 5, 1, 16'h5500);
        set_port(1, 6, 1, 16'h6600);
        bus.i_w_ready = 1'b0;
        bus.i_req     = 3'b011;
        vcyc = 0; tocnt = 0; got_done = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            tick();
            if (bus.o_w_valid === 1'b1) vcyc++;
            if (bus.o_timeout === 1'b1) tocnt++;
            if (bus.o_done !== 3'b000) begin
                got_done = 1'b1;
                n_tests++;
                if (bus.o_done !== 3'b001 || bus.o_timeout !== 1'b1) begin
                    n_fail++;
                    $display("FAIL to_done: got done=%b to=%b want 001/1", bus.o_done, bus.o_timeout);
                end
                bus.i_req[0] = 1'b0;
            end
        end
        n_tests++;
        if (!got_done || vcyc != TO || tocnt != 1) begin
            n_fail++;
            $display("FAIL to_window: got done=%0d valid_cycles=%0d pulses=%0d want 1/%0d/1",
                     got_done, vcyc, tocnt, TO);
        end
        got_gnt = 1'b0;
        for (int c = 0; c < 4 && !got_gnt; c++) begin
            tick();
            if (bus.o_gnt !== 3'b000) got_gnt = 1'b1;
        end
        n_tests++;
        if (bus.o_gnt !== 3'b010) begin
            n_fail++;
            $display("FAIL to_next_gnt: got %b want 010", bus.o_gnt);
        end
        // Ready arrives in the final handshake cycle: treated as ready, no timeout.
        vcyc = 0; tocnt = 0; got_done = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            tick();
            if (bus.o_w_valid === 1'b1) vcyc++;
            if (bus.o_timeout === 1'b1) tocnt++;
            if (bus.o_done !== 3'b000) begin
                got_done = 1'b1;
                n_tests++;
                if (bus.o_done !== 3'b010 || bus.o_timeout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL to_tie_done: got done=%b to=%b want 010/0", bus.o_done, bus.o_timeout);
                end
            end else if (bus.o_w_valid === 1'b1 && vcyc == TO) begin
                bus.i_w_ready = 1'b1;
            end
        end
        n_tests++;
        if (!got_done || vcyc != TO || tocnt != 0) begin
            n_fail++;
            $display("FAIL to_tie_window: got done=%0d valid_cycles=%0d pulses=%0d want 1/%0d/0",
                     got_done, vcyc, tocnt, TO);
        end
        bus.i_req     = 3'b000;
        bus.i_w_ready = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        set_port(0, 100, 8, 16'hC000);
        set_port(1, 200, 1, 16'hD000);
        bus.i_req = 3'b001;
        repeat (4) tick(); // t4: third word on the bus
        n_tests++;
        if (bus.o_xintf_z_to_d_ce !== 1'b1 || bus.o_xintf_z_to_d_addr !== 9'd102) begin
            n_fail++;
            $display("FAIL rstmid_pre: got ce=%b addr=%0d want 1/102",
                     bus.o_xintf_z_to_d_ce, bus.o_xintf_z_to_d_addr);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.o_gnt !== 3'b000 || bus.o_data_ack !== 3'b000 || bus.o_done !== 3'b000 ||
            bus.o_timeout !== 1'b0 || bus.o_w_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: got gnt=%b ack=%b done=%b to=%b valid=%b want all 0",
                     bus.o_gnt, bus.o_data_ack, bus.o_done, bus.o_timeout, bus.o_w_valid);
        end
        n_tests++;
        if (bus.o_xintf_z_to_d_ce !== 1'b0 || bus.o_xintf_z_to_d_addr !== 9'd0 ||
            bus.o_xintf_z_to_d_din !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_bram: got ce=%b addr=%0d din=%h want 0/0/0000",
                     bus.o_xintf_z_to_d_ce, bus.o_xintf_z_to_d_addr, bus.o_xintf_z_to_d_din);
        end
        bus.i_req = 3'b011;
        cnt[0]    = 16'd0;
        tick();
        n_tests++;
        if (bus.o_done !== 3'b000 || bus.o_gnt !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_held: got done=%b gnt=%b want 000/000", bus.o_done, bus.o_gnt);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (bus.o_gnt !== 3'b001 || bus.o_done !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_first_gnt: got gnt=%b done=%b want 001/000", bus.o_gnt, bus.o_done);
        end
        bus.i_req = 3'b000;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        ack_n         = 3'b000;
        bus.i_req     = 3'b000;
        bus.i_w_ready = 1'b0;
        bus.i_req_addr = '0;
        bus.i_req_len  = '0;
        for (int n = 0; n < 3; n++) begin
            base[n] = 16'd0;
            cnt[n]  = 16'd0;
        end

        test_reset();
        test_single_burst();
        test_round_robin();
        test_addr_wrap();
        test_zero_length();
        test_timeout();
        test_reset_mid_burst();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
